yarp_fetch_unit: RTL

//  Instruction fetch stage for the yarp core: owns the PC, issues instruction-memory requests and

---
 rtl/yarp_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/yarp_fetch_unit.sv
// yarp instruction fetch: owns the PC, issues imem requests and
// hands fetched words to decode over a valid/ready handshake.
module yarp_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        kill_q;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] next_seq;

  assign redirect    = branch_taken_i | jump_i;
  assign target      = {branch_target_i[31:2], 2'b00};
  assign next_seq    = instr_pc_o + 32'd4;
  assign imem_addr_o = req_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      kill_q        <= 1'b0;
      imem_req_o    <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      misaligned_o  <= 1'b0;
    end else begin
      misaligned_o <= redirect && (branch_target_i[1:0] != 2'b00);
      if (redirect) pc_q <= target;
      unique case (state_q)
        IDLE: begin
          req_addr_q <= redirect ? target : pc_q;
          imem_req_o <= 1'b1;
          state_q    <= REQ;
        end
        REQ: begin
          // address must not move while the request is pending
          if (redirect) kill_q <= 1'b1;
          if (imem_gnt_i) begin
            imem_req_o <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect || kill_q) begin
              kill_q     <= 1'b0;
              req_addr_q <= redirect ? target : pc_q;
              imem_req_o <= 1'b1;
              state_q    <= REQ;
            end else begin
              instr_o       <= imem_rdata_i;
              instr_pc_o    <= req_addr_q;
              instr_valid_o <= 1'b1;
              state_q       <= HOLD;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid_o <= 1'b0;
            req_addr_q    <= target;
            imem_req_o    <= 1'b1;
            state_q       <= REQ;
          end else if (instr_ready_i) begin
            instr_valid_o <= 1'b0;
            pc_q          <= next_seq;
            req_addr_q    <= next_seq;
            imem_req_o    <= 1'b1;
            state_q       <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
